// File: rtl/pla_sweep_driver_if.sv
// Bundle of the sweep driver's control, status and cone-stimulus signals.
// The slave modport is the driver itself; the master modport is the
// controlling logic together with the combinational cone under test.
interface pla_sweep_driver_if;
  logic        start;
  logic        abort;
  logic [6:0]  dut_x;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  ones_cnt;
  logic [15:0] signature;

  modport master (
    output start, abort, dut_y,
    input  dut_x, busy, done, aborted, ones_cnt, signature
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_x, busy, done, aborted, ones_cnt, signature
  );
endinterface

// File: rtl/pla_sweep_driver.sv
// Exhaustive sweep driver for a 7-input/1-output combinational cone.
// Applies all 128 input vectors in ascending order, one per cycle, counts
// the vectors that produce a 1 and optionally compresses the responses.
// Optional feature: define PLA_SWEEP_MISR_EN to build the 16-bit response
// signature register; without it the signature output is a constant zero.
module pla_sweep_driver (
  input logic               clk,
  input logic               rst_n,
  pla_sweep_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e      state_q;
  logic [6:0]  dutX_q;
  logic        busy_q;
  logic        done_q;
  logic        aborted_q;
  logic [7:0]  onesCnt_q;
  logic [7:0]  onesCnt_d;
  logic        lastVector;

  // Next count if the current response is sampled, and last-vector detect.
  always_comb begin
    onesCnt_d  = onesCnt_q + {7'd0, bus.dut_y};
    lastVector = (dutX_q == 7'h7F);
  end

  // Sweep sequencer: state, stimulus vector, ones counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dutX_q    <= 7'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      onesCnt_q <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= SWEEP;
            busy_q    <= 1'b1;
            dutX_q    <= 7'h00;
            onesCnt_q <= 8'h00;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            dutX_q    <= 7'h00;
          end else begin
            onesCnt_q <= onesCnt_d;
            if (lastVector) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dutX_q  <= 7'h00;
            end else begin
              dutX_q <= dutX_q + 7'd1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          dutX_q  <= 7'h00;
        end
      endcase
    end
  end

`ifdef PLA_SWEEP_MISR_EN
  logic [15:0] sig_q;
  logic [15:0] sig_d;
  logic        startSweep;
  logic        sampleEn;

  // Signature shift-in of the current response and load/sample qualifiers.
  always_comb begin
    startSweep = (state_q == IDLE) && bus.start;
    sampleEn   = (state_q == SWEEP) && !bus.abort;
    sig_d      = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3] ^ bus.dut_y};
  end

  // Signature register: cleared at sweep start, updated per sampled vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 16'h0000;
    end else if (startSweep) begin
      sig_q <= 16'h0000;
    end else if (sampleEn) begin
      sig_q <= sig_d;
    end
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = 16'h0000;
`endif

  assign bus.dut_x    = dutX_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.ones_cnt = onesCnt_q;

endmodule

// File: tb/tb_pla_sweep_driver.sv
// Scoreboard bench for pla_sweep_driver: each sweep pushes its expected
// result when launched; a monitor pops and compares on every done/aborted
// pulse. The signature expectation follows PLA_SWEEP_MISR_EN.
module tb_pla_sweep_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  pla_sweep_driver_if bus ();

  pla_sweep_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          isAbort;
    logic [7:0]  ones;
    logic [15:0] sig;
    int          busyCycles;
  } exp_t;

  exp_t expQ[$];
  int   doneCycles[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busyRun = 0;
  int   mode = 0;

  // Cone model selected by mode: 0 tied low, 1 tied high, 2 x[0], 3 x==0x55.
  function automatic logic coneY(int m, logic [6:0] x);
    case (m)
      1:       return 1'b1;
      2:       return x[0];
      3:       return (x == 7'h55);
      default: return 1'b0;
    endcase
  endfunction

  // Combinational cone driving the response back into the driver.
  always_comb begin
    bus.dut_y = coneY(mode, bus.dut_x);
  end

  // Cycle counter used for pulse timing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  // Expected signature over the first nVec vectors of the cone in mode m.
  function automatic logic [15:0] sigModel(int m, int nVec);
    logic [15:0] s;
    s = 16'h0000;
`ifdef PLA_SWEEP_MISR_EN
    for (int i = 0; i < nVec; i++) begin
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3] ^ coneY(m, 7'(i))};
    end
`else
    if (nVec < 0) s = 16'hFFFF;
`endif
    return s;
  endfunction

  function automatic void pushExp(bit ab, logic [7:0] ones, logic [15:0] sig, int busyC);
    exp_t e;
    e.isAbort    = ab;
    e.ones       = ones;
    e.sig        = sig;
    e.busyCycles = busyC;
    expQ.push_back(e);
  endfunction

  // Monitor: compares every completion pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyRun = 0;
    end else begin
      if (bus.busy) busyRun++;
      if (bus.done || bus.aborted) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected pulse: done=%0b aborted=%0b, expected none", bus.done, bus.aborted);
        end else begin
          e = expQ.pop_front();
          check("done flag",    32'(bus.done),      32'(!e.isAbort));
          check("aborted flag", 32'(bus.aborted),   32'(e.isAbort));
          check("ones_cnt",     32'(bus.ones_cnt),  32'(e.ones));
          check("signature",    32'(bus.signature), 32'(e.sig));
          check("busy cycles",  32'(busyRun),       32'(e.busyCycles));
          check("dut_x in FIN", 32'(bus.dut_x),     32'h0);
          check("busy in FIN",  32'(bus.busy),      32'h0);
        end
        if (bus.done) doneCycles.push_back(cyc);
        busyRun = 0;
      end
    end
  end

  int startCyc;

  // Launch a sweep: hold start for n cycles starting at a falling edge.
  task automatic applyStimulus(int m, int n);
    mode = m;
    @(negedge clk);
    bus.start = 1'b1;
    startCyc = cyc;
    repeat (n) @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait until all expected pulses were seen and the driver is idle.
  task automatic checkOutput(int bound);
    int n = 0;
    while ((expQ.size() != 0 || bus.busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      $display("[TB] FAIL drain timeout: %0d pulses outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic waitVector(logic [6:0] v, int bound);
    int n = 0;
    while (bus.dut_x != v && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      $display("[TB] FAIL vector wait: dut_x=%0h, expected %0h", bus.dut_x, v);
    end
  endtask

  task automatic checkAllZero(string tag);
    check({tag, " dut_x"},     32'(bus.dut_x),     32'h0);
    check({tag, " busy"},      32'(bus.busy),      32'h0);
    check({tag, " done"},      32'(bus.done),      32'h0);
    check({tag, " aborted"},   32'(bus.aborted),   32'h0);
    check({tag, " ones_cnt"},  32'(bus.ones_cnt),  32'h0);
    check({tag, " signature"}, 32'(bus.signature), 32'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset state, then release and confirm abort is ignored while idle.
    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    bus.abort = 1'b0;
    check("idle busy", 32'(bus.busy), 32'h0);

    // Cone tied low.
    pushExp(1'b0, 8'd0, 16'h0000, 128);
    applyStimulus(0, 1);
    checkOutput(300);

    // Cone tied high, with done latency from the start-presenting cycle.
    doneCycles.delete();
    pushExp(1'b0, 8'h80, sigModel(1, 128), 128);
    applyStimulus(1, 1);
    checkOutput(300);
    if (doneCycles.size() == 1) check("done latency", 32'(doneCycles[0] - startCyc), 32'd129);
    else check("done count", 32'(doneCycles.size()), 32'd1);

    // Cone = x[0] and cone = (x == 0x55).
    pushExp(1'b0, 8'd64, sigModel(2, 128), 128);
    applyStimulus(2, 1);
    checkOutput(300);
    pushExp(1'b0, 8'd1, sigModel(3, 128), 128);
    applyStimulus(3, 1);
    checkOutput(300);

    // Abort on the cycle applying vector 0x0A.
    pushExp(1'b1, 8'd10, sigModel(1, 10), 11);
    applyStimulus(1, 1);
    waitVector(7'h0A, 40);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput(20);

    // Asynchronous reset in the middle of a sweep.
    applyStimulus(1, 1);
    waitVector(7'h40, 200);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post reset busy", 32'(bus.busy), 32'h0);
    pushExp(1'b0, 8'd64, sigModel(2, 128), 128);
    applyStimulus(2, 1);
    checkOutput(300);

    // Start held for 300 cycles: three back-to-back sweeps.
    doneCycles.delete();
    pushExp(1'b0, 8'h80, sigModel(1, 128), 128);
    pushExp(1'b0, 8'h80, sigModel(1, 128), 128);
    pushExp(1'b0, 8'h80, sigModel(1, 128), 128);
    applyStimulus(1, 300);
    checkOutput(300);
    check("back-to-back count", 32'(doneCycles.size()), 32'd3);
    if (doneCycles.size() == 3) begin
      check("done spacing 1", 32'(doneCycles[1] - doneCycles[0]), 32'd130);
      check("done spacing 2", 32'(doneCycles[2] - doneCycles[1]), 32'd130);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
